// File: rtl/fetch_decode_if.sv
// Instruction-memory channel: one-cycle request pulse with address, later a
// single-cycle valid response carrying the 32-bit instruction word.
interface fetch_decode_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_decode.sv
// RV64I fetch stage: PC register, instruction-memory handshake and field/immediate
// decode feeding the ifid register, with stall and branch/jump redirect.
module fetch_decode #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_if.master        imem,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic                  fetch_valid,
  output logic [6:0]            opcode_out,
  output logic [4:0]            rd_out,
  output logic [4:0]            rs1_out,
  output logic [4:0]            rs2_out,
  output logic [2:0]            funct3_out,
  output logic [6:0]            funct7_out,
  output logic [63:0]           imm_out,
  output logic [63:0]           PC_out
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_reg;
  logic [63:0] pc_reg;
  logic [63:0] redirect_target;
  logic [63:0] imm_next;
  logic [31:0] instr;

  assign instr           = imem.imem_rdata;
  assign redirect_target = redirect_pc & ~64'h3;

  // The request pulse is simply "in REQ"; gating with reset keeps it low while reset is held.
  assign imem.imem_req  = (state_reg == S_REQ) && !reset;
  assign imem.imem_addr = pc_reg;

  always_comb begin
    imm_next = '0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
        imm_next = {{52{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm_next = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm_next = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_next = {{32{instr[31]}}, instr[31:12], 12'b0};
      7'b1101111:
        imm_next = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_REQ;
      pc_reg      <= RESET_PC;
      fetch_valid <= 1'b0;
      opcode_out  <= '0;
      rd_out      <= '0;
      rs1_out     <= '0;
      rs2_out     <= '0;
      funct3_out  <= '0;
      funct7_out  <= '0;
      imm_out     <= '0;
      PC_out      <= '0;
    end else if (redirect_valid) begin
      // A request already on the bus must have its response drained before refetching.
      pc_reg      <= redirect_target;
      fetch_valid <= 1'b0;
      case (state_reg)
        S_REQ:   state_reg <= S_DRAIN;
        S_WAIT:  state_reg <= imem.imem_rvalid ? S_REQ : S_DRAIN;
        S_HOLD:  state_reg <= S_REQ;
        S_DRAIN: state_reg <= imem.imem_rvalid ? S_REQ : S_DRAIN;
        default: state_reg <= S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            opcode_out  <= instr[6:0];
            rd_out      <= instr[11:7];
            funct3_out  <= instr[14:12];
            rs1_out     <= instr[19:15];
            rs2_out     <= instr[24:20];
            funct7_out  <= instr[31:25];
            imm_out     <= imm_next;
            PC_out      <= pc_reg;
            fetch_valid <= 1'b1;
            state_reg   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_reg      <= pc_reg + 64'd4;
            fetch_valid <= 1'b0;
            state_reg   <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem.imem_rvalid) begin
            state_reg <= S_REQ;
          end
        end
        default: begin
          state_reg <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus a randomized run,
// all checked against a field/immediate reference model built from the ISA rules.
module tb_fetch_decode;

  typedef struct packed {
    logic        v;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [63:0] pc;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_out, rs1_out, rs2_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [63:0] imm_out, PC_out;
  dec_t        obs;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_pc = 64'h0;

  fetch_decode_if bus();

  fetch_decode #(.RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .opcode_out     (opcode_out),
    .rd_out         (rd_out),
    .rs1_out        (rs1_out),
    .rs2_out        (rs2_out),
    .funct3_out     (funct3_out),
    .funct7_out     (funct7_out),
    .imm_out        (imm_out),
    .PC_out         (PC_out)
  );

  always #5 clk = ~clk;

  assign obs = {fetch_valid, opcode_out, rd_out, rs1_out, rs2_out,
                funct3_out, funct7_out, imm_out, PC_out};

  // Immediate value computed arithmetically from the format rules.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint v;
    v = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
        v = (ins[31] ? -2048 : 0) + longint'(ins[30:20]);
      end
      7'h23: begin
        v = (ins[31] ? -2048 : 0) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
      end
      7'h63: begin
        v = (ins[31] ? -4096 : 0) + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        v = (ins[31] ? -longint'(64'h8000_0000) : 0) + longint'(ins[30:12]) * 4096;
      end
      7'h6F: begin
        v = (ins[31] ? -1048576 : 0) + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
    dec_t d;
    d.v   = 1'b1;
    d.op  = ins[6:0];
    d.rd  = ins[11:7];
    d.f3  = ins[14:12];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.f7  = ins[31:25];
    d.imm = ref_imm(ins);
    d.pc  = pc;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until a request is visible (bounded); returns its address.
  task automatic wait_req(output bit got, output logic [63:0] addr);
    got  = 1'b0;
    addr = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) begin
        got  = 1'b1;
        addr = bus.imem_addr;
        break;
      end
      tick();
    end
  endtask

  // Called in the request cycle; returns just after the edge that samples the response.
  task automatic respond(input int k, input logic [31:0] ins);
    repeat (k) tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = ins;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
  endtask

  task automatic test_reset();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_req: got %b expected 0", bus.imem_req);
    end
    checks++;
    if (obs !== dec_t'(0)) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
      fails++; $display("FAIL first_req: req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'h0;
    $display("reset: first request at %h", bus.imem_addr);
  endtask

  task automatic test_addi();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
      fails++; $display("FAIL addi_req: req=%b addr=%h expected 1/%h", bus.imem_req, bus.imem_addr, exp_pc);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL addi_wait: valid=%b req=%b expected 0/0", fetch_valid, bus.imem_req);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (obs !== ref_decode(32'h0050_0093, exp_pc)) begin
      fails++; $display("FAIL addi_decode: got %h expected %h", obs, ref_decode(32'h0050_0093, exp_pc));
    end
    checks++;
    if (opcode_out !== 7'h13 || rd_out !== 5'd1 || rs1_out !== 5'd0 || funct3_out !== 3'd0 || imm_out !== 64'd5 || PC_out !== 64'd0) begin
      fails++; $display("FAIL addi_fields: op=%h rd=%0d rs1=%0d f3=%0d imm=%h pc=%h", opcode_out, rd_out, rs1_out, funct3_out, imm_out, PC_out);
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd4) begin
      fails++; $display("FAIL addi_next_req: req=%b addr=%h expected 1/4", bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'd4;
    $display("addi: imm=%h pc=%h", imm_out, PC_out);
  endtask

  task automatic test_branch_lui();
    bit got;
    logic [63:0] addr;
    logic [31:0] words [2];
    logic [63:0] imms [2];
    words[0] = 32'hFE00_0EE3; imms[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    words[1] = 32'h0000_12B7; imms[1] = 64'h0000_0000_0000_1000;
    for (int i = 0; i < 2; i++) begin
      wait_req(got, addr);
      checks++;
      if (!got || addr !== exp_pc) begin
        fails++; $display("FAIL bl_req%0d: got=%b addr=%h expected %h", i, got, addr, exp_pc);
      end
      respond(1, words[i]);
      checks++;
      if (imm_out !== imms[i] || obs !== ref_decode(words[i], exp_pc)) begin
        fails++; $display("FAIL bl_decode%0d: imm=%h expected %h obs=%h", i, imm_out, imms[i], obs);
      end
      $display("branch/lui %0d: op=%h imm=%h", i, opcode_out, imm_out);
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic test_stall();
    bit got;
    logic [63:0] addr;
    logic [31:0] ins;
    dec_t held;
    ins = 32'h8765_4103;
    wait_req(got, addr);
    checks++;
    if (!got || addr !== exp_pc) begin
      fails++; $display("FAIL stall_req: got=%b addr=%h expected %h", got, addr, exp_pc);
    end
    respond(2, ins);
    held = ref_decode(ins, exp_pc);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== held || bus.imem_req !== 1'b0) begin
        fails++; $display("FAIL stall_hold%0d: obs=%h req=%b expected %h req=0", i, obs, bus.imem_req, held);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc + 64'd4) begin
      fails++; $display("FAIL stall_release: req=%b addr=%h expected 1/%h", bus.imem_req, bus.imem_addr, exp_pc + 64'd4);
    end
    exp_pc = exp_pc + 64'd4;
    $display("stall: held 5 cycles, next addr %h", bus.imem_addr);
  endtask

  task automatic test_redirect_wait();
    bit got;
    logic [63:0] addr;
    wait_req(got, addr);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL rw_drain: valid=%b req=%b expected 0/0", fetch_valid, bus.imem_req);
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL rw_early_req: req=%b expected 0", bus.imem_req);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin
      fails++; $display("FAIL rw_refetch: valid=%b req=%b addr=%h expected 0/1/100", fetch_valid, bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'h100;
    $display("redirect in WAIT: refetch at %h", bus.imem_addr);
  endtask

  task automatic test_redirect_same();
    bit got;
    logic [63:0] addr;
    wait_req(got, addr);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_12B7;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h203;
    tick();
    bus.imem_rvalid = 1'b0;
    redirect_valid  = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) begin
      fails++; $display("FAIL rs_refetch: valid=%b req=%b addr=%h expected 0/1/200", fetch_valid, bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'h200;
    $display("redirect with rvalid: refetch at %h", bus.imem_addr);
  endtask

  task automatic test_redirect_hold();
    bit got;
    logic [63:0] addr;
    wait_req(got, addr);
    respond(1, 32'h0041_8193);
    checks++;
    if (obs !== ref_decode(32'h0041_8193, exp_pc)) begin
      fails++; $display("FAIL rh_decode: got %h expected %h", obs, ref_decode(32'h0041_8193, exp_pc));
    end
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1000;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h1000) begin
      fails++; $display("FAIL rh_refetch: valid=%b req=%b addr=%h expected 0/1/1000", fetch_valid, bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'h1000;
    $display("redirect in HOLD over stall: refetch at %h", bus.imem_addr);
  endtask

  task automatic test_wrap();
    bit got;
    logic [63:0] addr;
    wait_req(got, addr);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL wrap_drain_req: req=%b expected 0", bus.imem_req);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_006F;
    tick();
    bus.imem_rvalid = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    wait_req(got, addr);
    checks++;
    if (!got || addr !== exp_pc) begin
      fails++; $display("FAIL wrap_req: got=%b addr=%h expected %h", got, addr, exp_pc);
    end
    respond(1, 32'hFFDF_F0EF);
    checks++;
    if (obs !== ref_decode(32'hFFDF_F0EF, exp_pc)) begin
      fails++; $display("FAIL wrap_decode: got %h expected %h", obs, ref_decode(32'hFFDF_F0EF, exp_pc));
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
      fails++; $display("FAIL wrap_next: req=%b addr=%h expected 1/0", bus.imem_req, bus.imem_addr);
    end
    exp_pc = 64'h0;
    $display("wrap: next addr %h", bus.imem_addr);
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    logic [63:0] addr;
    wait_req(got, addr);
    respond(1, 32'h0010_0113);
    wait_req(got, addr);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== dec_t'(0) || bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL rst_mid: obs=%h req=%b expected 0/0", obs, bus.imem_req);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
      fails++; $display("FAIL rst_req: req=%b addr=%h expected 1/0", bus.imem_req, bus.imem_addr);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0010_0113;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0) begin
      fails++; $display("FAIL rst_late: valid=%b expected 0", fetch_valid);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h8000_0237;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (obs !== ref_decode(32'h8000_0237, 64'h0)) begin
      fails++; $display("FAIL rst_refetch: got %h expected %h", obs, ref_decode(32'h8000_0237, 64'h0));
    end
    exp_pc = 64'h4;
    $display("reset mid-WAIT: late response ignored, imm=%h", imm_out);
  endtask

  task automatic test_random();
    bit got;
    logic [63:0] addr, tgt;
    logic [31:0] ins;
    logic [6:0] ops [12];
    int k, s;
    dec_t held;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    for (int n = 0; n < 40; n++) begin
      wait_req(got, addr);
      checks++;
      if (!got || addr !== exp_pc) begin
        fails++; $display("FAIL rnd_req%0d: got=%b addr=%h expected %h", n, got, addr, exp_pc);
      end
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      k = $urandom_range(1, 4);
      if ($urandom_range(0, 4) == 0) begin
        tgt = {$urandom, $urandom};
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        if (k == 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = ins;
        end
        tick();
        redirect_valid  = 1'b0;
        bus.imem_rvalid = 1'b0;
        if (k > 1) begin
          repeat (k - 2) tick();
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = ins;
          tick();
          bus.imem_rvalid = 1'b0;
        end
        checks++;
        if (fetch_valid !== 1'b0) begin
          fails++; $display("FAIL rnd_redirect%0d: valid=%b expected 0", n, fetch_valid);
        end
        exp_pc = tgt & ~64'h3;
        $display("rnd %0d: redirect k=%0d to %h", n, k, exp_pc);
      end else begin
        respond(k, ins);
        held = ref_decode(ins, exp_pc);
        checks++;
        if (obs !== held) begin
          fails++; $display("FAIL rnd_decode%0d: ins=%h got %h expected %h", n, ins, obs, held);
        end
        s = $urandom_range(0, 3);
        if (s > 0) begin
          stall = 1'b1;
          repeat (s) tick();
          stall = 1'b0;
          checks++;
          if (obs !== held || bus.imem_req !== 1'b0) begin
            fails++; $display("FAIL rnd_stall%0d: obs=%h req=%b expected %h req=0", n, obs, bus.imem_req, held);
          end
        end
        $display("rnd %0d: ins=%h k=%0d stall=%0d imm=%h pc=%h", n, ins, k, s, imm_out, PC_out);
        exp_pc = exp_pc + 64'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch_lui();
    test_stall();
    test_redirect_wait();
    test_redirect_same();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
